// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson sequencer.
//   - state_e: controller FSM states
//   - johnson_next / johnson_legal / johnson_phase: helpers working on a
//     JW_MAX-wide vector of which only the low n bits are meaningful.
//     The callers zero-extend their register value into this width.
//   - JOHNSON_N: default Johnson register width
package johnson_pkg;

  localparam int JOHNSON_N = 3;
  localparam int JW_MAX    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits [n-1:0] set.
  function automatic logic [JW_MAX-1:0] johnson_mask(input int n);
    logic [JW_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // One step of the twisted ring. Forward shifts left and feeds ~MSB into
  // the LSB; reverse shifts right and feeds ~LSB into the MSB.
  function automatic logic [JW_MAX-1:0] johnson_next(input logic [JW_MAX-1:0] a,
                                                     input logic dir,
                                                     input int n);
    logic              msb;
    logic [JW_MAX-1:0] nxt;
    msb = 1'b0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i == n - 1) msb = a[i];
    end
    if (!dir) nxt = (a << 1) | {{(JW_MAX-1){1'b0}}, ~msb};
    else      nxt = (a >> 1) | ({{(JW_MAX-1){1'b0}}, ~a[0]} << (n - 1));
    return nxt & johnson_mask(n);
  endfunction

  // k-th code of the forward sequence: k ones filling from the LSB for
  // k <= n, then zeros filling from the LSB.
  function automatic logic [JW_MAX-1:0] johnson_code(input int k, input int n);
    logic [JW_MAX-1:0] code;
    code = '0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i < n) begin
        if (k <= n) code[i] = (i < k);
        else        code[i] = (i >= k - n);
      end
    end
    return code;
  endfunction

  // One-hot position of a within the forward sequence; zero if illegal.
  function automatic logic [2*JW_MAX-1:0] johnson_phase(input logic [JW_MAX-1:0] a,
                                                        input int n);
    logic [2*JW_MAX-1:0] ph;
    ph = '0;
    for (int k = 0; k < 2 * JW_MAX; k++) begin
      if (k < 2 * n) ph[k] = (a == johnson_code(k, n));
    end
    return ph;
  endfunction

  function automatic logic johnson_legal(input logic [JW_MAX-1:0] a, input int n);
    return |johnson_phase(a, n);
  endfunction

endpackage

// File: rtl/johnson_seq_ctrl_core.sv
// Johnson register. clr_i wins over en_i; en_i advances one step in the
// direction given by dir_i.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : force register to zero on the next edge
//   en_i      : step on the next edge
//   dir_i     : 0 forward, 1 reverse
//   a_o       : register value
module johnson_core
  import johnson_pkg::*;
#(
  parameter int N_BITS = JOHNSON_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              dir_i,
  output logic [N_BITS-1:0] a_o
);

  logic [N_BITS-1:0] a_q, a_d;
  logic [JW_MAX-1:0] a_ext, nxt_ext;

  assign a_ext   = JW_MAX'(a_q);
  assign nxt_ext = johnson_next(a_ext, dir_i, N_BITS);

  always_comb begin
    a_d = a_q;
    if (clr_i)     a_d = '0;
    else if (en_i) a_d = N_BITS'(nxt_ext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_q <= '0;
    else     a_q <= a_d;
  end

  assign a_o = a_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequences a Johnson counter for a programmed number of full 2N-step
// rounds, with hold, abort, direction select, one-hot phase decode, a done
// pulse and a sticky illegal-state flag.
//   clk, rst : clock, asynchronous active-high reset
//   start    : pulse, accepted only in IDLE; latches rounds and dir
//   rounds   : number of full rounds (0 gives a bare done pulse)
//   dir      : 0 forward, 1 reverse
//   hold     : freezes stepping while high
//   abort    : returns to IDLE with A=0 from any state, no done pulse
//   A        : Johnson register
//   phase    : one-hot position of A in forward order, zero if illegal
//   busy     : high in RUN and PAUSE
//   done     : one-cycle pulse on normal completion
//   err      : sticky illegal-state flag, cleared by rst or accepted start
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int N_BITS = JOHNSON_N,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    rounds,
  input  logic                dir,
  input  logic                hold,
  input  logic                abort,
  output logic [N_BITS-1:0]   A,
  output logic [2*N_BITS-1:0] phase,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q;
  logic [CNT_W-1:0]    rem_q;
  logic                dir_q, busy_q, done_q, err_q;

  logic [JW_MAX-1:0]   a_ext, nxt_ext;
  logic [2*JW_MAX-1:0] ph_ext;
  logic                a_legal, stepping, wraps;

  assign a_ext   = JW_MAX'(A);
  assign ph_ext  = johnson_phase(a_ext, N_BITS);
  assign a_legal = |ph_ext;
  assign nxt_ext = johnson_next(a_ext, dir_q, N_BITS);
  assign wraps   = (nxt_ext == '0);

  // The edge that leaves PAUSE already steps, so each hold-high cycle costs
  // exactly one cycle of latency.
  assign stepping = !hold && (state_q == ST_RUN || state_q == ST_PAUSE);

  johnson_core #(.N_BITS(N_BITS)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr_i (abort || !a_legal),
    .en_i  (stepping),
    .dir_i (dir_q),
    .a_o   (A)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        rem_q   <= '0;
      end else if (!a_legal) begin
        // The core clears A on this same edge.
        err_q   <= 1'b1;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        rem_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              err_q <= 1'b0;
              if (rounds != '0) begin
                rem_q   <= rounds;
                dir_q   <= dir;
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_RUN, ST_PAUSE: begin
            if (hold) begin
              state_q <= ST_PAUSE;
            end else begin
              state_q <= ST_RUN;
              // Returning to zero closes one round.
              if (wraps) begin
                rem_q <= rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign phase = (2*N_BITS)'(ph_ext);
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
